dsp_accum: RTL
==============

Name: dsp_accum

Overview:
Sequential accumulate stage directly downstream of the combinational dsp multiplier. It consumes each multiplier result together with the command that produced it and extends it to accumulator width using command-dependent signedness. It sums beats under an opcode carried with each beat and emits the accumulated total through a valid/ready handshake. This lets dot-product and MAC sequences run back-to-back from the issuing sequencer.

Parameters:
ACC_W, 56, accumulator width in bits, signed two's complement; legal range 49..64.
COUNT_W, 16, width of the beat counter.
SAT, 1, 1 = saturate on signed overflow, 0 = wrap modulo 2^ACC_W.

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
in_valid  input  1  beat present
in_ready  output  1  stage can accept a beat
in_command  input  32  command (integer) the dsp was given for this product
in_product  input  64  dsp resp_result; only bits [47:0] are used
in_op  input  2  00 LOAD, 01 ACC, 10 ACC_LAST, 11 CLEAR
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_result  output  64  accumulated value, sign-extended from ACC_W
out_count  output  COUNT_W  number of product beats summed into out_result
out_ovf  output  1  sticky overflow seen during this accumulation

Behaviour:
- A beat is accepted when in_valid && in_ready at the clk rising edge. A result is taken when out_valid && out_ready.
- in_ready = !out_valid || out_ready. This allows same-cycle result drain and new-beat accept.
- Extension (ext) of in_product[47:0]:
  - Commands 3, 4, 7: sign-extend bit 47 to ACC_W.
  - Commands 0, 2, 6: zero-extend.
  - Any other command: beat is accepted and treated as ext = 0. out_count still increments, except on CLEAR.
- Op on an accepted beat:
  - LOAD: acc = ext; count = 1; ovf = 0.
  - ACC: acc = acc + ext; count += 1.
  - ACC_LAST: same as ACC, then present the result.
  - CLEAR: acc = 0; count = 0; ovf = 0; product ignored; no result.
- Overflow: detected when the ACC_W-bit signed sum carries out of range.
  - SAT=1: clamp to +(2^(ACC_W-1)-1) or -2^(ACC_W-1).
  - SAT=0: wrap.
  - In both cases ovf is set sticky until the next LOAD, CLEAR, or result drain.
- count saturates at all-ones and never wraps.
- States:
  - IDLE: acc 0, no beats.
  - RUN: accumulating.
  - HOLD: out_valid high.
- Transitions:
  - IDLE→RUN on LOAD or ACC.
  - IDLE→HOLD on ACC_LAST (a single-beat result).
  - RUN→RUN on ACC or LOAD.
  - RUN→IDLE on CLEAR.
  - RUN→HOLD on ACC_LAST.
  - HOLD→IDLE on drain with no accept.
  - HOLD→RUN or HOLD→HOLD on drain with a same-cycle accept. The new beat starts from acc=0, count=0, ovf=0; ACC and LOAD are then equivalent.
- Latency: an ACC_LAST accepted at edge n gives out_valid=1 after edge n, with out_result, out_count and out_ovf stable until drained.
- In HOLD with out_ready=0, in_ready=0 and all state is frozen.
- Reset, also when applied mid-accumulation or in HOLD, clears immediately: out_valid=0, out_result=0, out_count=0, out_ovf=0, acc=0, count=0, state IDLE. in_ready is 1 during and after reset.
- out_result is registered. Its value is 0 whenever out_valid=0 after reset; otherwise it holds the last result.

Test Plan:
- Mixed signedness: LOAD cmd0 prod 48'h10, then ACC cmd3 prod 48'hFFFF_FFFF_FFF0, then ACC_LAST cmd2 prod 48'h5 -> out_result 64'h5, out_count 3, out_ovf 0, out_valid one cycle after the third accept.
- Single-beat: from IDLE, ACC_LAST cmd7 prod 48'h8000_0000_0000 -> out_result 64'hFFFF_8000_0000_0000, out_count 1.
- Saturation, SAT=1 ACC_W=56: 257 beats of cmd0 prod 48'h7FFF_FFFF_FFFF with the last beat ACC_LAST -> out_result 64'h007F_FFFF_FFFF_FFFF, out_ovf 1, out_count 257. With SAT=0 the result is the wrapped value sign-extended and out_ovf is 1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after ACC_LAST -> in_ready 0 and outputs stable.
  - Raise out_ready with in_valid=1 and op LOAD prod 48'h3 cmd0 -> drain and accept in the same cycle; the next ACC_LAST prod 48'h1 gives 64'h4, out_count 2.
- CLEAR/unknown command: ACC prod 48'h9 cmd0, then CLEAR, then ACC_LAST cmd5 prod 48'h7 -> out_result 0, out_count 1.
- Reset in HOLD: assert reset asynchronously while out_valid=1 -> out_valid, out_result, out_count and out_ovf are 0 immediately; after release, LOAD then ACC_LAST behave as from IDLE.

Source files
------------

// File: rtl/dsp_accum.sv
// dsp_accum: accumulate stage behind the dsp multiplier.
// Extends each 48-bit product by command signedness, sums beats under the
// per-beat opcode and hands the total out over a valid/ready handshake.
module dsp_accum #(
   parameter int ACC_W   = 56,
   parameter int COUNT_W = 16,
   parameter bit SAT     = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_command,
   input  logic [63:0]        in_product,
   input  logic [1:0]         in_op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [63:0]        out_result,
   output logic [COUNT_W-1:0] out_count,
   output logic               out_ovf
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_ACC   = 2'b01;
   localparam logic [1:0] OP_LAST  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   state_t                    state_q, state_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [COUNT_W-1:0]        cnt_q, cnt_d;
   logic                      ovf_q, ovf_d;
   logic [63:0]               res_q, res_d;
   logic [COUNT_W-1:0]        ocnt_q, ocnt_d;
   logic                      oovf_q, oovf_d;

   logic                      accept, drain;
   logic signed [ACC_W-1:0]   ext, sum, acc_nx;
   logic                      sum_ovf;
   logic [COUNT_W-1:0]        cnt_inc;
   logic                      unused_hi;

   // Only the low 48 product bits carry the multiplier result.
   assign unused_hi = ^in_product[63:48];

   assign out_valid  = (state_q == S_HOLD);
   assign in_ready   = !out_valid || out_ready;
   assign accept     = in_valid && in_ready;
   assign drain      = out_valid && out_ready;
   assign out_result = res_q;
   assign out_count  = ocnt_q;
   assign out_ovf    = oovf_q;

   // Extend the product to accumulator width; unknown commands add nothing.
   always_comb begin
      ext = '0;
      case (in_command)
         32'd3, 32'd4, 32'd7: ext = {{(ACC_W-48){in_product[47]}}, in_product[47:0]};
         32'd0, 32'd2, 32'd6: ext = {{(ACC_W-48){1'b0}}, in_product[47:0]};
         default:             ext = '0;
      endcase
   end

   // Signed add with overflow detect, then clamp or wrap; count saturates.
   always_comb begin
      sum     = acc_q + ext;
      sum_ovf = (acc_q[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
      acc_nx  = sum;
      if (SAT && sum_ovf)
         acc_nx = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
      cnt_inc = (&cnt_q) ? cnt_q : cnt_q + COUNT_W'(1);
   end

   // Next-state and datapath. The running accumulator is zeroed when a
   // result is captured, so a beat accepted during drain starts fresh.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      res_d   = res_q;
      ocnt_d  = ocnt_q;
      oovf_d  = oovf_q;
      if (drain) begin
         state_d = S_IDLE;
         res_d   = '0;
         ocnt_d  = '0;
         oovf_d  = 1'b0;
      end
      if (accept) begin
         case (in_op)
            OP_LOAD: begin
               acc_d   = ext;
               cnt_d   = COUNT_W'(1);
               ovf_d   = 1'b0;
               state_d = S_RUN;
            end
            OP_ACC: begin
               acc_d   = acc_nx;
               cnt_d   = cnt_inc;
               ovf_d   = ovf_q | sum_ovf;
               state_d = S_RUN;
            end
            OP_LAST: begin
               res_d   = 64'(acc_nx);
               ocnt_d  = cnt_inc;
               oovf_d  = ovf_q | sum_ovf;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = S_HOLD;
            end
            default: begin
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         res_q   <= '0;
         ocnt_q  <= '0;
         oovf_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         res_q   <= res_d;
         ocnt_q  <= ocnt_d;
         oovf_q  <= oovf_d;
      end
   end

endmodule
